inst_fetch_ctrl: RTL
====================

Name: inst_fetch_ctrl

Overview:
Instruction fetch sequencer for the single-cycle core. It owns the program counter, drives the combinational instruction ROM address, and holds fetched words in a one-entry output slot with a valid/ready handshake toward decode. J/JAL targets are resolved locally. Branches and JR arrive as redirects from execute. It also detects the "J self" halt idiom and flags illegal fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ROM_WORDS, 32, number of ROM words; legal fetch range is 0 to ROM_WORDS*4-4

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
rom_address  out  32  byte address to the instruction ROM; always equals pc
rom_instruction  in  32  combinational ROM data for rom_address
redirect_valid  in  1  one-cycle pulse; execute requests a PC change (branch taken, JR)
redirect_pc  in  32  target byte address for the redirect
out_valid  out  1  output slot holds a valid instruction
out_ready  in  1  decode accepts the slot this cycle
out_instruction  out  32  instruction in the slot
out_pc  out  32  byte address of out_instruction
out_pc_plus4  out  32  out_pc+4, used as the JAL link value
halted  out  1  a self-jump has been delivered; fetch has stopped
fault  out  1  sticky; illegal fetch address detected
fetch_count  out  32  number of completed out_valid&out_ready handshakes; wraps at 2^32

Behaviour:
- Reset values, applied asynchronously while reset_n=0:
  - pc=RESET_PC, state=FETCH.
  - out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=0.
  - halted=0, fault=0, fetch_count=0.
- States: FETCH, HALT, FAULT. halted=(state==HALT). fault=(state==FAULT).
- load = (state==FETCH) & ~redirect_valid & (~out_valid | out_ready).
- Address check is made when load=1:
  - If pc[1:0]!=0 or pc>=ROM_WORDS*4: no slot load, out_valid<=0, state<=FAULT.
  - Otherwise the instruction is legal to load.
- Legal load, with the slot captured in the same cycle:
  - out_instruction<=rom_instruction, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1.
  - Fetch latency: ROM word at pc appears on the slot one cycle after pc is presented.
- Next PC on a legal load:
  - If opcode rom_instruction[31:26] is 6'b000010 (J) or 6'b000011 (JAL): pc<={pc_plus4[31:28], rom_instruction[25:0], 2'b00}.
  - Otherwise: pc<=pc+4. Addition is modulo 2^32.
- Halt detection: a loaded J (opcode 000010 only) whose target equals pc moves state to HALT. The slot still delivers that instruction.
- No load, no redirect: pc, slot and state hold. If out_valid&out_ready, out_valid<=0.
- Backpressure: while out_valid=1 and out_ready=0, slot contents and pc are stable.
- redirect_valid=1 has priority over load in the same cycle:
  - pc<=redirect_pc and out_valid<=0 (slot flushed, even if out_ready=1).
  - fetch_count still increments if that cycle's handshake occurred.
  - The flushed word is not re-fetched. The next load uses redirect_pc.
- redirect_valid in HALT: state<=FETCH and pc<=redirect_pc.
- redirect_valid in FAULT: ignored. FAULT exits only by reset.
- Redirect target legality is checked at its first fetch, not on arrival.
- In HALT and FAULT: no loads. A pending valid slot still completes its handshake normally.
- fetch_count increments on every out_valid&out_ready, in any state.
- Reset mid-operation: all state returns to reset values immediately; no handshake completes in that cycle.

Decomposition:
- Shared package/header inst_fetch_defs:
  - OPC_J=6'b000010 and OPC_JAL=6'b000011.
  - State encodings ST_FETCH=2'd0, ST_HALT=2'd1, ST_FAULT=2'd2.
  - Helper constant for the opcode field position [31:26].
- One natural sub-module, next_pc_calc (combinational):
  - Inputs: pc, instruction.
  - Outputs: pc_plus4, jump_target, is_jump, is_self_jump.

Test Plan:
- Reset, then out_ready=1 with the team program in ROM -> rom_address=0 on the first cycle. Next cycle: out_valid=1, out_instruction=32'h3C01_0000, out_pc=0. Following slots carry pc 0x04 and 0x08.
- Fetch reaches 0x0C, which holds JAL 32'h0C00_0018 -> out_pc_plus4=0x10. Next rom_address=0x60. The slot after it shows pc 0x60 and instruction 32'h0000_4020.
- Hold out_ready=0 for 5 cycles with a slot valid at pc 0x04 -> out_instruction, out_pc and rom_address stay constant. fetch_count does not change. Raising out_ready resumes at 0x08.
- redirect_valid=1 with redirect_pc=0x10, in a cycle where out_ready=1 and out_valid=1 -> next cycle out_valid=0 and rom_address=0x10. One cycle later the slot shows pc 0x10 and instruction 32'hAC82_0000. fetch_count increments by 1.
- Fetch at 0x5C of 32'h0800_0017 -> slot delivers it and halted=1. rom_address stays 0x5C with no further loads. A redirect to 0x00 clears halted and fetch resumes.
- Redirect to 0x62, then redirect to 0x80 after reset -> fault=1 at the first fetch attempt of each, out_valid=0. A later redirect to 0x00 leaves fault=1. Asserting reset_n=0 clears fault.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_defs: shared opcodes, FSM encoding and the output slot record
// used by the instruction fetch sequencer and its next-PC helper.
package inst_fetch_defs;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  // Opcode field position within an instruction word
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // One-entry output slot toward decode
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } slot_t;

endpackage

// File: rtl/inst_fetch_ctrl_next_pc_calc.sv
// next_pc_calc: combinational next-PC helper.
//   pc, instruction   -> word being fetched and its address
//   pc_plus4          -> sequential successor (mod 2^32)
//   jump_target       -> J/JAL pseudo-direct target
//   is_jump           -> opcode is J or JAL
//   is_self_jump      -> plain J whose target is its own address (halt idiom)
module next_pc_calc
  import inst_fetch_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic [31:0] jump_target,
  output logic        is_jump,
  output logic        is_self_jump
);
  logic [5:0] opc;

  assign opc          = instruction[OPC_HI:OPC_LO];
  assign pc_plus4     = pc + 32'd4;
  assign jump_target  = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign is_jump      = (opc == OPC_J) || (opc == OPC_JAL);
  // JAL to itself is not the halt idiom; only plain J counts
  assign is_self_jump = (opc == OPC_J) && (jump_target == pc);
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch sequencer.
//   clk, reset_n         -> clock, async active-low reset
//   rom_address          -> always the current pc
//   rom_instruction      -> combinational ROM data at rom_address
//   redirect_valid/_pc   -> PC change from execute (flushes the slot)
//   out_valid/out_ready  -> one-entry slot handshake toward decode
//   out_instruction/_pc/_pc_plus4 -> slot contents
//   halted, fault        -> FSM status (fault is sticky until reset)
//   fetch_count          -> completed handshakes, wrapping
module inst_fetch_ctrl
  import inst_fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);
  localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS) << 2;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  slot_t       slot, slot_nx;
  logic        vld, vld_nx;

  logic [31:0] pc_plus4, jump_target;
  logic        is_jump, is_self_jump;
  logic        hs, load, bad_addr;

  next_pc_calc u_npc (
    .pc           (pc),
    .instruction  (rom_instruction),
    .pc_plus4     (pc_plus4),
    .jump_target  (jump_target),
    .is_jump      (is_jump),
    .is_self_jump (is_self_jump)
  );

  assign hs       = vld & out_ready;
  assign load     = (state == ST_FETCH) & ~redirect_valid & (~vld | out_ready);
  assign bad_addr = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      slot        <= '0;
      vld         <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      slot  <= slot_nx;
      vld   <= vld_nx;
      if (hs) fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    slot_nx  = slot;
    vld_nx   = hs ? 1'b0 : vld;
    case (state)
      ST_FETCH: begin
        if (redirect_valid) begin
          // Flushed word is dropped; the redirect target is fetched next
          pc_nx  = redirect_pc;
          vld_nx = 1'b0;
        end else if (load) begin
          if (bad_addr) begin
            vld_nx   = 1'b0;
            state_nx = ST_FAULT;
          end else begin
            slot_nx = '{instr: rom_instruction, pc: pc, pc_plus4: pc_plus4};
            vld_nx  = 1'b1;
            pc_nx   = is_jump ? jump_target : pc_plus4;
            // The self-jump is still delivered; fetch stops behind it
            if (is_self_jump) state_nx = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          vld_nx   = 1'b0;
          state_nx = ST_FETCH;
        end
      end
      default: ; // ST_FAULT: only reset leaves; pending slot may still drain
    endcase
  end

  assign rom_address     = pc;
  assign out_valid       = vld;
  assign out_instruction = slot.instr;
  assign out_pc          = slot.pc;
  assign out_pc_plus4    = slot.pc_plus4;
  assign halted          = (state == ST_HALT);
  assign fault           = (state == ST_FAULT);
endmodule
